// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - request FIFO, single-op issue FSM and watchdog-guarded result hold for the FPU
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  input  logic [1:0]  in_sel_i,
  input  logic [1:0]  in_round_i,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic [1:0]  fpu_sel_o,
  output logic [1:0]  fpu_round_o,
  output logic        fpu_start_o,
  input  logic        fpu_done_i,
  input  logic [31:0] fpu_y_i,
  input  logic        fpu_overflow_i,
  input  logic        fpu_error_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_y_o,
  output logic        out_overflow_o,
  output logic        out_error_o,
  output logic        out_timeout_o,
  output logic        busy_o
);

  localparam int               REQ_W    = 68;
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC00000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic [31:0] fpu_a_q, fpu_a_d;
  logic [31:0] fpu_b_q, fpu_b_d;
  logic [1:0]  fpu_sel_q, fpu_sel_d;
  logic [1:0]  fpu_round_q, fpu_round_d;
  logic        fpu_start_q, fpu_start_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_y_q, out_y_d;
  logic        out_overflow_q, out_overflow_d;
  logic        out_error_q, out_error_d;
  logic        out_timeout_q, out_timeout_d;

  logic             push;
  logic             pop;
  logic [REQ_W-1:0] head;

  // A full FIFO refuses a push even when a pop happens in the same cycle
  assign in_ready_o = (count_q != FULL);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: pop one request, pulse start, wait for done or watchdog, hold result
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    fpu_sel_d      = fpu_sel_q;
    fpu_round_d    = fpu_round_q;
    fpu_start_d    = 1'b0;
    out_valid_d    = out_valid_q;
    out_y_d        = out_y_q;
    out_overflow_d = out_overflow_q;
    out_error_d    = out_error_q;
    out_timeout_d  = out_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {fpu_a_d, fpu_b_d, fpu_sel_d, fpu_round_d} = head;
          fpu_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A real completion on the last watchdog cycle still wins
        if (fpu_done_i) begin
          out_y_d        = fpu_y_i;
          out_overflow_d = fpu_overflow_i;
          out_error_d    = fpu_error_i;
          out_timeout_d  = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = S_HOLD;
        end else if (wcnt_q == CNT_LAST) begin
          out_y_d        = QNAN;
          out_overflow_d = 1'b0;
          out_error_d    = 1'b1;
          out_timeout_d  = 1'b1;
          out_valid_d    = 1'b1;
          state_d        = S_HOLD;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset; occupancy alone decides what is readable
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {in_a_i, in_b_i, in_sel_i, in_round_i};
  end

  // State, FIFO control and output registers; reset aborts any op in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      wcnt_q         <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      fpu_sel_q      <= '0;
      fpu_round_q    <= '0;
      fpu_start_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_y_q        <= '0;
      out_overflow_q <= 1'b0;
      out_error_q    <= 1'b0;
      out_timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      fpu_sel_q      <= fpu_sel_d;
      fpu_round_q    <= fpu_round_d;
      fpu_start_q    <= fpu_start_d;
      out_valid_q    <= out_valid_d;
      out_y_q        <= out_y_d;
      out_overflow_q <= out_overflow_d;
      out_error_q    <= out_error_d;
      out_timeout_q  <= out_timeout_d;
    end
  end

  assign fpu_a_o        = fpu_a_q;
  assign fpu_b_o        = fpu_b_q;
  assign fpu_sel_o      = fpu_sel_q;
  assign fpu_round_o    = fpu_round_q;
  assign fpu_start_o    = fpu_start_q;
  assign out_valid_o    = out_valid_q;
  assign out_y_o        = out_y_q;
  assign out_overflow_o = out_overflow_q;
  assign out_error_o    = out_error_q;
  assign out_timeout_o  = out_timeout_q;
  assign busy_o         = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - scoreboard bench for fpu_issue_ctrl with behavioural FPU responder
module tb_fpu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_sel, in_round;
  logic [31:0] fpu_a, fpu_b;
  logic [1:0]  fpu_sel, fpu_round;
  logic        fpu_start, fpu_done;
  logic [31:0] fpu_y;
  logic        fpu_ovf, fpu_err;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic        out_ovf, out_err, out_to, busy;

  logic        resp_done, resp_ovf, resp_err;
  logic [31:0] resp_y;
  logic        stray_done;
  logic [31:0] stray_y;

  assign fpu_done = resp_done | stray_done;
  assign fpu_y    = stray_done ? stray_y : resp_y;
  assign fpu_ovf  = stray_done ? 1'b1 : resp_ovf;
  assign fpu_err  = stray_done ? 1'b1 : resp_err;

  fpu_issue_ctrl #(.DEPTH(4), .PTR_W(2), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_sel_i(in_sel), .in_round_i(in_round),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_sel_o(fpu_sel), .fpu_round_o(fpu_round),
    .fpu_start_o(fpu_start), .fpu_done_i(fpu_done), .fpu_y_i(fpu_y),
    .fpu_overflow_i(fpu_ovf), .fpu_error_i(fpu_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_y_o(out_y),
    .out_overflow_o(out_ovf), .out_error_o(out_err), .out_timeout_o(out_to),
    .busy_o(busy)
  );

  int n_chk, n_fail, start_cnt, rst_gen;
  logic [34:0] sb[$];
  logic [67:0] iq[$];
  bit rnd_ready;
  logic ready_fix;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FPU: latency and result are a pure function of the request
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] y, output logic ovf, output logic err,
                                output logic to, output int d);
    to  = (a[5:4] == 2'b11);
    d   = int'(a[3:0]) + 1;
    y   = a ^ {b[15:0], b[31:16]};
    ovf = b[0];
    err = b[1];
    if (a == 32'h41700000 && b == 32'h41E00000) begin
      y = 32'h422C0000; ovf = 1'b0; err = 1'b0; to = 1'b0; d = 3;
    end
    if (b == 32'h3F800000) begin
      y = 32'h3F800000; ovf = 1'b1; err = 1'b0;
    end
  endfunction

  // Offer one request for one cycle; on acceptance record expected issue and result
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                       input logic [1:0] r, output bit acc);
    logic [31:0] y;
    logic ovf, err, to;
    int d;
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = s; in_round = r;
    @(negedge clk);
    acc = in_ready && rst_n;
    if (acc) begin
      model(a, b, y, ovf, err, to, d);
      iq.push_back({a, b, s, r});
      sb.push_back(to ? {32'h7FC00000, 1'b0, 1'b1, 1'b1} : {y, ovf, err, 1'b0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < limit) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_in_time", (i < limit), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk); #2;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && fpu_start) start_cnt++;
  end

  // Monitor: pop and compare on handshake; stalled results must stay put
  logic [34:0] held, cur;
  bit stalled;
  initial begin
    stalled = 0;
    forever begin
      @(negedge clk);
      cur = {out_y, out_ovf, out_err, out_to};
      if (!rst_n) stalled = 0;
      else begin
        if (stalled) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_stable", cur, held);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else chk("result", cur, sb.pop_front());
          stalled = 0;
        end else if (out_valid) begin
          stalled = 1;
          held = cur;
        end else stalled = 0;
      end
    end
  end

  // FPU responder: check issued operands, drive done after the modelled latency
  logic [67:0] r_req;
  logic [31:0] r_y;
  logic r_ovf, r_err, r_to;
  int r_d, r_g, r_last;
  initial begin
    resp_done = 0; resp_y = 32'hDEADBEEF; resp_ovf = 0; resp_err = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && fpu_start) begin
        r_g = rst_gen;
        if (iq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          r_req = iq.pop_front();
          chk("issue_operands", {fpu_a, fpu_b, fpu_sel, fpu_round}, r_req);
          model(r_req[67:36], r_req[35:4], r_y, r_ovf, r_err, r_to, r_d);
          r_last = r_to ? 16 : r_d;
          for (int c = 1; c <= r_last + 1; c++) begin
            @(posedge clk); #1;
            if (rst_gen != r_g) break;
            resp_done = (c == (r_to ? 17 : r_d));
            resp_y    = resp_done ? r_y : 32'hDEADBEEF;
            resp_ovf  = resp_done ? r_ovf : 1'b0;
            resp_err  = resp_done ? r_err : 1'b0;
            if (c == 1) chk("start_single_cycle", fpu_start, 0);
            if (c <= r_last) chk("no_early_valid", out_valid, 0);
            else chk("valid_latency", out_valid, 1);
            if (c == r_last) chk("operands_stable", {fpu_a, fpu_b, fpu_sel, fpu_round}, r_req);
          end
          @(posedge clk); #1;
          resp_done = 0; resp_y = 32'hDEADBEEF; resp_ovf = 0; resp_err = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  bit acc;
  int s0;
  logic [34:0] snap;
  initial begin
    n_chk = 0; n_fail = 0; start_cnt = 0; rst_gen = 0;
    rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_sel = 0; in_round = 0;
    stray_done = 0; stray_y = 0; rnd_ready = 0; ready_fix = 1; out_ready = 1;

    // reset values, and pushes offered during reset are not taken
    @(posedge clk); #1;
    in_valid = 1; in_a = $urandom; in_b = $urandom;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_regs", {out_y, out_ovf, out_err, out_to, fpu_a, fpu_b}, 0);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk); rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_push_busy", busy, 0);
    chk("rst_no_start", start_cnt, 0);

    // basic op: 15.0 + 28.0, done three cycles after start
    s0 = start_cnt;
    offer(32'h41700000, 32'h41E00000, 2'b00, 2'b00, acc);
    chk("t1_accept", acc, 1);
    wait_drain(200);
    chk("t1_one_start", start_cnt - s0, 1);

    // back-to-back pushes with a stalled output: 1 in HOLD + 4 queued, 6th refused
    ready_fix = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      offer(($urandom & 32'hFFFFFFC0) | 32'(i << 8), $urandom, 2'(i), 2'(i + 1), acc);
      chk("t2_accept", acc, (i < 5));
    end
    chk("t2_full_in_ready", in_ready, 0);
    ready_fix = 1;
    wait_drain(400);

    // watchdog: never completes, then a normal op behind it
    offer(32'h12345630, $urandom, 2'b01, 2'b10, acc);
    offer(32'h00000001, $urandom, 2'b10, 2'b01, acc);
    wait_drain(400);

    // done on the last watchdog cycle beats the timeout
    offer(32'h0000000F, 32'h3F800000, 2'b11, 2'b11, acc);
    wait_drain(400);

    // stray done in HOLD must not disturb the held result
    ready_fix = 0;
    repeat (2) @(posedge clk);
    #1;
    offer(32'hA5A5A501, $urandom, 2'b00, 2'b11, acc);
    repeat (10) @(posedge clk);
    #1;
    snap = {out_y, out_ovf, out_err, out_to};
    stray_done = 1; stray_y = $urandom;
    repeat (2) @(posedge clk);
    #1;
    stray_done = 0;
    chk("t5_hold_valid", out_valid, 1);
    chk("t5_hold_data", {out_y, out_ovf, out_err, out_to}, snap);
    ready_fix = 1;
    wait_drain(200);
    // stray done in IDLE
    s0 = start_cnt;
    stray_done = 1; stray_y = $urandom;
    repeat (3) @(posedge clk);
    #1;
    stray_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_idle_valid", out_valid, 0);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_start", start_cnt - s0, 0);

    // reset in mid-WAIT with two ops queued
    offer(32'h0000000F, $urandom, 2'b01, 2'b01, acc);
    offer(32'h00000002, $urandom, 2'b01, 2'b01, acc);
    offer(32'h00000003, $urandom, 2'b01, 2'b01, acc);
    repeat (5) @(posedge clk);
    #2;
    rst_gen++;
    rst_n = 0;
    #1;
    chk("t6_start_low", fpu_start, 0);
    chk("t6_valid_low", out_valid, 0);
    chk("t6_busy_low", busy, 0);
    sb.delete();
    iq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    s0 = start_cnt;
    repeat (25) @(posedge clk);
    #1;
    chk("t6_no_issue", start_cnt - s0, 0);
    chk("t6_idle_busy", busy, 0);
    offer(32'h00000004, $urandom, 2'b10, 2'b10, acc);
    wait_drain(200);

    // randomized traffic with random backpressure
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        offer($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), acc);
      else begin
        @(posedge clk); #1;
      end
    end
    wait_drain(3000);
    rnd_ready = 0;
    chk("final_queues_empty", sb.size() + iq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
